alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_if.sv | 43 ++++
 rtl/alu_op_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, downstream-ALU and result signals of the ALU op sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface alu_op_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [3:0]  in_sel;
    logic        in_Cin;

    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_sel;
    logic        alu_Cin;
    logic [31:0] alu_Y;
    logic        alu_Cout;
    logic        alu_Negative;
    logic        alu_Zero;
    logic        alu_Overflow;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Y;
    logic [4:0]  out_flags;
    logic [2:0]  fifo_count;
    logic        sticky_err;

    modport slave (
        input  in_valid, in_A, in_B, in_sel, in_Cin,
        input  alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
        input  out_ready,
        output in_ready, alu_A, alu_B, alu_sel, alu_Cin,
        output out_valid, out_Y, out_flags, fifo_count, sticky_err
    );

    modport master (
        output in_valid, in_A, in_B, in_sel, in_Cin,
        output alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
        output out_ready,
        input  in_ready, alu_A, alu_B, alu_sel, alu_Cin,
        input  out_valid, out_Y, out_flags, fifo_count, sticky_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands in a 4-deep FIFO, issues them one at a time to an external
// combinational ALU, and returns each result with an illegal-opcode flag.
module alu_op_sequencer (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic        cin;
    } cmd_t;

    cmd_t        r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    state_t      r_state;
    cmd_t        r_alu;
    logic        r_out_valid;
    logic [31:0] r_out_y;
    logic [4:0]  r_out_flags;
    logic        r_sticky_err;

    logic        w_push;
    logic        w_pop;
    logic        w_illegal;
    cmd_t        w_in_cmd;

    assign w_in_cmd  = '{a: bus.in_A, b: bus.in_B, sel: bus.in_sel, cin: bus.in_Cin};
    assign w_push    = bus.in_valid && bus.in_ready;
    // A pop happens whenever the FSM loads a new head: from IDLE, or on a HOLD handshake.
    assign w_pop     = (r_count != 3'd0) &&
                       ((r_state == S_IDLE) || (r_state == S_HOLD && bus.out_ready));
    assign w_illegal = (r_alu.sel == 4'b1001) || (r_alu.sel == 4'b1110) || (r_alu.sel == 4'b1111);

    assign bus.in_ready   = !rst && (r_count != 3'd4);
    assign bus.alu_A      = r_alu.a;
    assign bus.alu_B      = r_alu.b;
    assign bus.alu_sel    = r_alu.sel;
    assign bus.alu_Cin    = r_alu.cin;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_Y      = r_out_y;
    assign bus.out_flags  = r_out_flags;
    assign bus.fifo_count = r_count;
    assign bus.sticky_err = r_sticky_err;

    // NOTE: storage is not reset; pointers and count define what is valid, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_cmd;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_IDLE;
            r_alu        <= '0;
            r_out_valid  <= 1'b0;
            r_out_y      <= '0;
            r_out_flags  <= '0;
            r_sticky_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu   <= r_mem[r_rd_ptr];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_out_y     <= bus.alu_Y;
                    r_out_flags <= {w_illegal, bus.alu_Cout, bus.alu_Negative,
                                    bus.alu_Zero, bus.alu_Overflow};
                    r_out_valid <= 1'b1;
                    if (w_illegal) r_sticky_err <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu   <= r_mem[r_rd_ptr];
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
